// File: rtl/decimal_accumulator_if.sv
// Byte-in / number-out handshake bundle for the decimal accumulator.
interface decimal_accumulator_if #(
  parameter int unsigned WIDTH = 32
);
  // Upstream side: converted bytes from the ASCII-to-number stage
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_value;

  // Downstream side: completed numbers towards the range/checker logic
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_overflow;
  logic [4:0]       out_digits;

  // Environment view: feeds bytes, consumes numbers
  modport master (
    output in_valid,
    output in_value,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_value,
    input  out_overflow,
    input  out_digits
  );

  // Accumulator view
  modport slave (
    input  in_valid,
    input  in_value,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_value,
    output out_overflow,
    output out_digits
  );
endinterface

// File: rtl/decimal_accumulator.sv
// Builds decimal numbers from converted digit bytes and emits each one when a
// delimiter byte closes it. Digits are 0x00..0x09; every other byte delimits.
module decimal_accumulator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  decimal_accumulator_if.slave bus
);

  // Product/sum width: acc*10+9 always fits in WIDTH+4 bits
  localparam int unsigned EXT_W      = WIDTH + 4;
  localparam int unsigned CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               ovf;

  logic               out_valid;
  logic [WIDTH-1:0]   out_value;
  logic               out_overflow;
  logic [CNT_W-1:0]   out_digits;

  logic               in_ready_c;
  logic               in_fire_c;
  logic               out_fire_c;
  logic               is_digit_c;
  logic [EXT_W-1:0]   step_c;
  logic               step_ovf_c;
  logic [CNT_W-1:0]   count_inc_c;

  // Upstream is stalled only while a completed number waits downstream
  assign in_ready_c  = (state != EMIT);
  assign in_fire_c   = bus.in_valid & in_ready_c;
  assign out_fire_c  = out_valid & bus.out_ready;

  // Unsigned digit test: anything above 9 is a delimiter
  assign is_digit_c  = (bus.in_value <= 8'd9);

  // Next accumulator value at extended width; upper bits flag overflow
  assign step_c      = (EXT_W'(acc) * EXT_W'(10)) + EXT_W'(bus.in_value[3:0]);
  assign step_ovf_c  = |step_c[EXT_W-1:WIDTH];

  // Digit count saturates so very long numbers still report 31
  assign count_inc_c = (count == CNT_MAX) ? count : count + CNT_W'(1);

  // Sequencing of accumulate / emit and the registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_overflow <= 1'b0;
      out_digits   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Leading or repeated delimiters are dropped silently
          if (in_fire_c && is_digit_c) begin
            acc   <= WIDTH'(bus.in_value[3:0]);
            count <= CNT_W'(1);
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end

        ACCUM: begin
          if (in_fire_c) begin
            if (is_digit_c) begin
              acc   <= step_c[WIDTH-1:0];
              ovf   <= ovf | step_ovf_c;
              count <= count_inc_c;
            end else begin
              // Delimiter closes the number; it is consumed, not forwarded
              out_value    <= acc;
              out_overflow <= ovf;
              out_digits   <= count;
              out_valid    <= 1'b1;
              state        <= EMIT;
            end
          end
        end

        EMIT: begin
          // Outputs hold until downstream takes the number
          if (out_fire_c) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the bus from the local registers
  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid;
  assign bus.out_value    = out_value;
  assign bus.out_overflow = out_overflow;
  assign bus.out_digits   = out_digits;

endmodule
